// File: rtl/run_ctrl.sv
// Run controller: streams an input block into data memory, runs the 8-bit core
// with a cycle budget, then streams a result block back out to the host.
module run_ctrl #(
  parameter int unsigned   AW      = 8,
  parameter int unsigned   DW      = 8,
  parameter int unsigned   CW      = 16,
  parameter logic [CW-1:0] MAX_CYC = 16'd4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_len,
  input  logic [AW-1:0] out_base,
  input  logic [AW:0]   out_len,
  input  logic          h_in_valid,
  input  logic [DW-1:0] h_in_data,
  output logic          h_in_ready,
  output logic          h_out_valid,
  output logic [DW-1:0] h_out_data,
  input  logic          h_out_ready,
  output logic          cpu_reset,
  input  logic          cpu_done,
  input  logic          cpu_mem_wr_en,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [DW-1:0] cpu_mem_din,
  output logic [DW-1:0] cpu_mem_dout,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          run_done,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_LEN  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_CYC = {{(CW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [AW-1:0] ld_base;
    logic [AW-1:0] out_base;
    logic [AW:0]   ld_len;
    logic [AW:0]   out_len;
  } cfg_t;

  function automatic logic [AW:0] sat_len(input logic [AW:0] len);
    return (len > FULL_LEN) ? FULL_LEN : len;
  endfunction

  logic [2:0]    state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [AW:0]   idx_q, idx_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          timed_out_q, timed_out_d;

  logic [AW:0]   ld_len_sat, out_len_sat;
  logic [CW-1:0] cycles_inc;
  logic          ld_last, out_last;

  assign ld_len_sat  = sat_len(ld_len);
  assign out_len_sat = sat_len(out_len);
  assign cycles_inc  = cycles_q + ONE_CYC;
  assign ld_last     = (idx_q == cfg_q.ld_len - ONE_LEN);
  assign out_last    = (idx_q == cfg_q.out_len - ONE_LEN);

  // One index serves both streams; it is re-zeroed whenever a stream starts.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    idx_d       = idx_q;
    cycles_d    = cycles_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d       = '{ld_base: ld_base, out_base: out_base,
                          ld_len: ld_len_sat, out_len: out_len_sat};
          idx_d       = '0;
          cycles_d    = '0;
          timed_out_d = 1'b0;
          state_d     = (ld_len_sat == '0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (h_in_valid) begin
          if (ld_last) begin
            idx_d   = '0;
            state_d = S_RUN;
          end else begin
            idx_d = idx_q + ONE_LEN;
          end
        end
      end
      S_RUN: begin
        if (cpu_done) begin
          state_d = (cfg_q.out_len == '0) ? S_FIN : S_UNLOAD;
        end else begin
          cycles_d = cycles_inc;
          if (cycles_inc == MAX_CYC) begin
            timed_out_d = 1'b1;
            state_d     = (cfg_q.out_len == '0) ? S_FIN : S_UNLOAD;
          end
        end
      end
      S_UNLOAD: begin
        if (h_out_ready) begin
          if (out_last) state_d = S_FIN;
          else          idx_d   = idx_q + ONE_LEN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      idx_q       <= '0;
      cycles_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      idx_q       <= idx_d;
      cycles_q    <= cycles_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Memory ownership mux; the core only ever sees the memory while in RUN.
  always_comb begin
    h_in_ready   = 1'b0;
    h_out_valid  = 1'b0;
    h_out_data   = '0;
    cpu_reset    = 1'b1;
    cpu_mem_dout = '0;
    mem_wr_en    = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    run_done     = 1'b0;
    case (state_q)
      S_LOAD: begin
        h_in_ready = 1'b1;
        mem_wr_en  = h_in_valid;
        mem_addr   = cfg_q.ld_base + idx_q[AW-1:0];
        mem_din    = h_in_data;
      end
      S_RUN: begin
        cpu_reset    = 1'b0;
        mem_wr_en    = cpu_mem_wr_en;
        mem_addr     = cpu_mem_addr;
        mem_din      = cpu_mem_din;
        cpu_mem_dout = mem_dout;
      end
      S_UNLOAD: begin
        h_out_valid = 1'b1;
        mem_addr    = cfg_q.out_base + idx_q[AW-1:0];
        h_out_data  = mem_dout;
      end
      S_FIN:   run_done = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign timed_out = timed_out_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: a table of run configurations with a memory model, a
// write scoreboard and an unload scoreboard, plus reset/ignore-start sequences.
module tb_run_ctrl;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int MAXC = 20;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] ld_base, out_base;
  logic [AW:0]   ld_len, out_len;
  logic          h_in_valid, h_in_ready;
  logic [DW-1:0] h_in_data;
  logic          h_out_valid, h_out_ready;
  logic [DW-1:0] h_out_data;
  logic          cpu_reset, cpu_done, cpu_mem_wr_en;
  logic [AW-1:0] cpu_mem_addr;
  logic [DW-1:0] cpu_mem_din, cpu_mem_dout;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          busy, run_done, timed_out;
  logic [CW-1:0] cycles;

  run_ctrl #(.AW(AW), .DW(DW), .CW(CW), .MAX_CYC(16'd20)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_base(ld_base), .ld_len(ld_len), .out_base(out_base), .out_len(out_len),
    .h_in_valid(h_in_valid), .h_in_data(h_in_data), .h_in_ready(h_in_ready),
    .h_out_valid(h_out_valid), .h_out_data(h_out_data), .h_out_ready(h_out_ready),
    .cpu_reset(cpu_reset), .cpu_done(cpu_done),
    .cpu_mem_wr_en(cpu_mem_wr_en), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_din(cpu_mem_din), .cpu_mem_dout(cpu_mem_dout),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .run_done(run_done), .timed_out(timed_out), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Data memory with asynchronous read, plus the bench's own reference copy.
  logic [DW-1:0] dmem    [0:255] = '{default: '0};
  logic [DW-1:0] ref_mem [0:255] = '{default: '0};
  assign mem_dout = dmem[mem_addr];
  always @(posedge clk) if (mem_wr_en) dmem[mem_addr] <= mem_din;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           wq[$];
  wr_t           mon_w;
  logic [DW-1:0] oq[$];

  typedef struct {
    logic [7:0] ld_base;
    logic [8:0] ld_len;
    logic [7:0] out_base;
    logic [8:0] out_len;
    int         done_cyc;
    bit         fixed, rnd_valid, stall, core_wr;
    int         exp_cyc;
    bit         exp_to;
  } vec_t;
  vec_t vecs[7];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every memory write must match the next expected write, in order.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      if (wq.size() == 0) chk("spurious_wr", 32'(mem_addr), 32'hFFFF);
      else begin
        mon_w = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_w.a));
        chk("wr_data", 32'(mem_din), 32'(mon_w.d));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    cpu_mem_wr_en = 1'b1;
    cpu_mem_addr  = 8'($urandom);
    cpu_mem_din   = 8'($urandom);
  endtask

  function automatic int sat(input logic [8:0] l);
    return (l > 9'd256) ? 256 : int'(l);
  endfunction

  task automatic run_vec(input vec_t v);
    int ln, on, i, j, g, st, exit_c;
    logic [7:0] d, a;
    ln = sat(v.ld_len);
    on = sat(v.out_len);
    exit_c = v.exp_to ? MAXC : v.exp_cyc + 1;
    junk();
    ld_base = v.ld_base; ld_len = v.ld_len; out_base = v.out_base; out_len = v.out_len;
    start = 1'b1;
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_mem_wr", 32'(mem_wr_en), 0);
    chk("idle_mem_addr", 32'(mem_addr), 0);
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_cycles", 32'(cycles), 0);
    chk("start_to", 32'(timed_out), 0);
    i = 0; g = 0;
    while (i < ln && g < 4000) begin
      chk("ld_ready", 32'(h_in_ready), 1);
      chk("ld_cpu_reset", 32'(cpu_reset), 1);
      chk("ld_cpu_dout", 32'(cpu_mem_dout), 0);
      junk();
      d = v.fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      h_in_data  = d;
      h_in_valid = v.rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("ld_wr_en", 32'(mem_wr_en), 32'(h_in_valid));
      if (h_in_valid) begin
        a = 8'(v.ld_base + 8'(i));
        wq.push_back('{a, d});
        ref_mem[a] = d;
        i++;
      end
      step();
      g++;
    end
    if (i < ln) chk("ld_timeout", 32'(i), 32'(ln));
    h_in_valid = 1'b0;
    for (int c = 1; c <= exit_c; c++) begin
      chk("run_cpu_reset", 32'(cpu_reset), 0);
      chk("run_cycles", 32'(cycles), 32'(c - 1));
      chk("run_ready", 32'(h_in_ready), 0);
      cpu_done = (c == v.done_cyc);
      if (v.core_wr && c <= on && !cpu_done) begin
        cpu_mem_wr_en = 1'b1;
        cpu_mem_addr  = 8'(v.out_base + 8'(c - 1));
        cpu_mem_din   = 8'(8'h5A + 3 * (c - 1));
      end else begin
        cpu_mem_wr_en = 1'b0;
        cpu_mem_addr  = 8'($urandom);
        cpu_mem_din   = 8'($urandom);
      end
      #1;
      chk("run_dout", 32'(cpu_mem_dout), 32'(ref_mem[cpu_mem_addr]));
      chk("run_mem_addr", 32'(mem_addr), 32'(cpu_mem_addr));
      if (cpu_mem_wr_en) begin
        wq.push_back('{cpu_mem_addr, cpu_mem_din});
        ref_mem[cpu_mem_addr] = cpu_mem_din;
      end
      step();
    end
    cpu_done = 1'b0;
    for (int k = 0; k < on; k++) oq.push_back(ref_mem[8'(v.out_base + 8'(k))]);
    j = 0; g = 0; st = 0;
    while (j < on && g < 4000) begin
      chk("ul_valid", 32'(h_out_valid), 1);
      chk("ul_cpu_reset", 32'(cpu_reset), 1);
      chk("ul_data", 32'(h_out_data), 32'(oq[0]));
      junk();
      h_out_ready = v.stall ? (st == 3) : 1'b1;
      #1;
      chk("ul_wr", 32'(mem_wr_en), 0);
      chk("ul_cpu_dout", 32'(cpu_mem_dout), 0);
      if (h_out_ready) begin
        void'(oq.pop_front());
        j++;
        st = 0;
      end else st++;
      step();
      g++;
    end
    if (j < on) chk("ul_timeout", 32'(j), 32'(on));
    h_out_ready = 1'b0;
    chk("fin_run_done", 32'(run_done), 1);
    chk("fin_busy", 32'(busy), 1);
    chk("fin_valid", 32'(h_out_valid), 0);
    chk("fin_cycles", 32'(cycles), 32'(v.exp_cyc));
    chk("fin_to", 32'(timed_out), 32'(v.exp_to));
    step();
    chk("post_run_done", 32'(run_done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_cycles", 32'(cycles), 32'(v.exp_cyc));
    chk("post_to", 32'(timed_out), 32'(v.exp_to));
    chk("post_cpu_reset", 32'(cpu_reset), 1);
    step();
    chk("post2_run_done", 32'(run_done), 0);
    chk("wq_empty", 32'(wq.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    reset = 1'b1; start = 1'b0;
    ld_base = '0; ld_len = '0; out_base = '0; out_len = '0;
    h_in_valid = 1'b0; h_in_data = '0; h_out_ready = 1'b0; cpu_done = 1'b0;
    junk();
    step();
    step();
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(h_in_ready), 0);
    chk("rst_out_valid", 32'(h_out_valid), 0);
    chk("rst_out_data", 32'(h_out_data), 0);
    chk("rst_mem_wr", 32'(mem_wr_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_cpu_dout", 32'(cpu_mem_dout), 0);
    chk("rst_run_done", 32'(run_done), 0);
    chk("rst_to", 32'(timed_out), 0);
    chk("rst_cycles", 32'(cycles), 0);
    reset = 1'b0;

    //          ld_base ld_len  out_b  out_len done fx rv st cw  cyc to
    vecs[0] = '{8'h10,  9'd3,   8'h20, 9'd1,   8,   1, 0, 0, 1,  7,  0};
    vecs[1] = '{8'h80,  9'd1,   8'h7F, 9'd2,   1,   0, 0, 0, 1,  0,  0};
    vecs[2] = '{8'h40,  9'd2,   8'h60, 9'd4,   20,  0, 0, 0, 1,  19, 0};
    vecs[3] = '{8'h33,  9'd0,   8'h00, 9'd0,   5,   0, 0, 0, 0,  4,  0};
    vecs[4] = '{8'd250, 9'd10,  8'd250,9'd10,  15,  0, 1, 1, 0,  14, 0};
    vecs[5] = '{8'h00,  9'd300, 8'h00, 9'h1FF, 3,   0, 0, 0, 0,  2,  0};
    vecs[6] = '{8'h40,  9'd2,   8'h60, 9'd4,   0,   0, 0, 0, 1,  20, 1};
    foreach (vecs[n]) run_vec(vecs[n]);

    // Reset mid-LOAD, with start held high (and new config) while busy.
    junk();
    ld_base = 8'h90; ld_len = 9'd5; out_base = 8'h00; out_len = 9'd1;
    start = 1'b1;
    step();
    ld_base = 8'hC0;
    for (int k = 0; k < 2; k++) begin
      junk();
      d = 8'($urandom);
      h_in_data = d; h_in_valid = 1'b1;
      #1;
      wq.push_back('{8'(8'h90 + 8'(k)), d});
      ref_mem[8'(8'h90 + 8'(k))] = d;
      step();
    end
    chk("ldrst_ready_before", 32'(h_in_ready), 1);
    h_in_valid = 1'b0; start = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ldrst_busy", 32'(busy), 0);
    chk("ldrst_cpu_reset", 32'(cpu_reset), 1);
    chk("ldrst_ready", 32'(h_in_ready), 0);
    chk("ldrst_cycles", 32'(cycles), 0);
    chk("ldrst_wq", 32'(wq.size()), 0);

    // Reset mid-RUN; start stays high with a non-empty load length while busy.
    ld_len = 9'd0; out_len = 9'd2; start = 1'b1;
    cpu_mem_wr_en = 1'b0;
    step();
    ld_len = 9'd3;
    for (int c = 1; c <= 5; c++) begin
      chk("runrst_cpu_reset", 32'(cpu_reset), 0);
      chk("runrst_busy", 32'(busy), 1);
      chk("runrst_cycles", 32'(cycles), 32'(c - 1));
      step();
    end
    chk("runrst_cycles_pre", 32'(cycles), 5);
    start = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("runrst_busy_post", 32'(busy), 0);
    chk("runrst_cpu_reset_post", 32'(cpu_reset), 1);
    chk("runrst_cycles_post", 32'(cycles), 0);
    chk("runrst_to_post", 32'(timed_out), 0);
    chk("runrst_run_done", 32'(run_done), 0);

    run_vec(vecs[0]);
    chk("final_wq", 32'(wq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
